// File: rtl/pacote_controle.sv
// Shared types and constants for the multicycle RV32I main controller:
// FSM states, opcodes, datapath select encodings and ALU operation classes.
package pacote_controle;

    typedef enum logic [3:0] {
        StInicio,
        StBusca,
        StDecodifica,
        StEndMem,
        StLeMem,
        StEscreveRegMem,
        StEscreveMem,
        StExecR,
        StExecI,
        StUlaWb,
        StBeq,
        StJal,
        StErro
    } estado_t;

    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] TIPO_R = 7'b0110011;
    localparam logic [6:0] TIPO_I = 7'b0010011;
    localparam logic [6:0] BEQ    = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam logic [1:0] ORIG_A_PC        = 2'b00;
    localparam logic [1:0] ORIG_A_PC_ANTIGO = 2'b01;
    localparam logic [1:0] ORIG_A_REG_A     = 2'b10;

    localparam logic [1:0] ORIG_B_REG_B  = 2'b00;
    localparam logic [1:0] ORIG_B_IMM    = 2'b01;
    localparam logic [1:0] ORIG_B_QUATRO = 2'b10;

    localparam logic [1:0] RES_ALU_OUT   = 2'b00;
    localparam logic [1:0] RES_DADOS_MEM = 2'b01;
    localparam logic [1:0] RES_ULA       = 2'b10;

    localparam logic [1:0] ULA_SOMA  = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    // Execute-stage successor of DECODIFICA; unknown opcodes trap in ERRO.
    function automatic estado_t proximo_decodifica(input logic [6:0] opcode);
        unique case (opcode)
            LW, SW:  return StEndMem;
            TIPO_R:  return StExecR;
            TIPO_I:  return StExecI;
            BEQ:     return StBeq;
            JAL:     return StJal;
            default: return StErro;
        endcase
    endfunction

endpackage

// File: rtl/saidas_controle.sv
// Combinational output decoder: strobes and datapath selects from the current
// state; only the fetch/memory handshake and the beq PC write depend on inputs.
module saidas_controle
    import pacote_controle::*;
(
    input  logic [3:0] estado_i,
    input  logic       mem_pronto_i,
    input  logic       zero_i,
    output logic       mem_req_o,
    output logic       origem_end_o,
    output logic       escreve_mem_o,
    output logic       escreve_ir_o,
    output logic       escreve_pc_o,
    output logic       escreve_reg_o,
    output logic [1:0] origem_a_o,
    output logic [1:0] origem_b_o,
    output logic [1:0] origem_resultado_o,
    output logic [1:0] operacao_ula_o
);

    always_comb begin
        mem_req_o          = 1'b0;
        origem_end_o       = 1'b0;
        escreve_mem_o      = 1'b0;
        escreve_ir_o       = 1'b0;
        escreve_pc_o       = 1'b0;
        escreve_reg_o      = 1'b0;
        origem_a_o         = ORIG_A_PC;
        origem_b_o         = ORIG_B_REG_B;
        origem_resultado_o = RES_ALU_OUT;
        operacao_ula_o     = ULA_SOMA;

        unique case (estado_t'(estado_i))
            StBusca: begin
                mem_req_o          = 1'b1;
                origem_a_o         = ORIG_A_PC;
                origem_b_o         = ORIG_B_QUATRO;
                operacao_ula_o     = ULA_SOMA;
                origem_resultado_o = RES_ULA;
                escreve_ir_o       = mem_pronto_i;
                escreve_pc_o       = mem_pronto_i;
            end
            StDecodifica: begin
                origem_a_o     = ORIG_A_PC_ANTIGO;
                origem_b_o     = ORIG_B_IMM;
                operacao_ula_o = ULA_SOMA;
            end
            StEndMem: begin
                origem_a_o     = ORIG_A_REG_A;
                origem_b_o     = ORIG_B_IMM;
                operacao_ula_o = ULA_SOMA;
            end
            StLeMem: begin
                mem_req_o    = 1'b1;
                origem_end_o = 1'b1;
            end
            StEscreveRegMem: begin
                origem_resultado_o = RES_DADOS_MEM;
                escreve_reg_o      = 1'b1;
            end
            // Write strobe held through the wait; memory commits on mem_pronto.
            StEscreveMem: begin
                mem_req_o     = 1'b1;
                origem_end_o  = 1'b1;
                escreve_mem_o = 1'b1;
            end
            StExecR: begin
                origem_a_o     = ORIG_A_REG_A;
                origem_b_o     = ORIG_B_REG_B;
                operacao_ula_o = ULA_FUNCT;
            end
            StExecI: begin
                origem_a_o     = ORIG_A_REG_A;
                origem_b_o     = ORIG_B_IMM;
                operacao_ula_o = ULA_FUNCT;
            end
            StUlaWb: begin
                origem_resultado_o = RES_ALU_OUT;
                escreve_reg_o      = 1'b1;
            end
            StBeq: begin
                origem_a_o         = ORIG_A_REG_A;
                origem_b_o         = ORIG_B_REG_B;
                operacao_ula_o     = ULA_SUB;
                origem_resultado_o = RES_ALU_OUT;
                escreve_pc_o       = zero_i;
            end
            // PC takes the target from ALUOut while the ALU forms PCantigo + 4.
            StJal: begin
                origem_a_o         = ORIG_A_PC_ANTIGO;
                origem_b_o         = ORIG_B_QUATRO;
                operacao_ula_o     = ULA_SOMA;
                origem_resultado_o = RES_ALU_OUT;
                escreve_pc_o       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle RV32I main controller: state register, next-state logic,
// retired-instruction counter and sticky illegal-opcode flag.
module unidade_controle_multiciclo
    import pacote_controle::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_pronto,
    output logic        mem_req,
    output logic        OrigemEnd,
    output logic        EscreveMem,
    output logic        EscreveIR,
    output logic        EscrevePC,
    output logic        EscreveReg,
    output logic [1:0]  OrigemA,
    output logic [1:0]  OrigemB,
    output logic [1:0]  OrigemResultado,
    output logic [1:0]  OperacaoULA,
    output logic        erro_instr,
    output logic [31:0] instr_concluidas
);

    estado_t     estado_q, estado_d;
    logic        erro_q;
    logic [31:0] instr_concluidas_q;
    logic        retira;
    logic        entra_erro;

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StInicio:        estado_d = StBusca;
            StBusca:         estado_d = mem_pronto ? StDecodifica : StBusca;
            StDecodifica:    estado_d = proximo_decodifica(opcode);
            StEndMem:        estado_d = (opcode == LW) ? StLeMem : StEscreveMem;
            StLeMem:         estado_d = mem_pronto ? StEscreveRegMem : StLeMem;
            StEscreveRegMem: estado_d = StBusca;
            StEscreveMem:    estado_d = mem_pronto ? StBusca : StEscreveMem;
            StExecR:         estado_d = StUlaWb;
            StExecI:         estado_d = StUlaWb;
            StUlaWb:         estado_d = StBusca;
            StBeq:           estado_d = StBusca;
            StJal:           estado_d = StUlaWb;
            StErro:          estado_d = StErro;
            default:         estado_d = StInicio;
        endcase
    end

    // Every retiring path ends in exactly one of these transitions into BUSCA.
    assign retira = (estado_q == StEscreveRegMem)
                  | ((estado_q == StEscreveMem) & mem_pronto)
                  | (estado_q == StUlaWb)
                  | (estado_q == StBeq);

    assign entra_erro = (estado_q == StDecodifica) & (estado_d == StErro);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q           <= StInicio;
            erro_q             <= 1'b0;
            instr_concluidas_q <= 32'd0;
        end else begin
            estado_q <= estado_d;
            if (entra_erro) begin
                erro_q <= 1'b1;
            end
            if (retira) begin
                instr_concluidas_q <= instr_concluidas_q + 32'd1;
            end
        end
    end

    saidas_controle u_saidas (
        .estado_i           (estado_q),
        .mem_pronto_i       (mem_pronto),
        .zero_i             (zero),
        .mem_req_o          (mem_req),
        .origem_end_o       (OrigemEnd),
        .escreve_mem_o      (EscreveMem),
        .escreve_ir_o       (EscreveIR),
        .escreve_pc_o       (EscrevePC),
        .escreve_reg_o      (EscreveReg),
        .origem_a_o         (OrigemA),
        .origem_b_o         (OrigemB),
        .origem_resultado_o (OrigemResultado),
        .operacao_ula_o     (OperacaoULA)
    );

    assign erro_instr       = erro_q;
    assign instr_concluidas = instr_concluidas_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle controller: per-cycle output vectors,
// retirement count, illegal-opcode trap and asynchronous reset abort.
module tb_unidade_controle_multiciclo;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_pronto;
    logic        mem_req;
    logic        OrigemEnd;
    logic        EscreveMem;
    logic        EscreveIR;
    logic        EscrevePC;
    logic        EscreveReg;
    logic [1:0]  OrigemA;
    logic [1:0]  OrigemB;
    logic [1:0]  OrigemResultado;
    logic [1:0]  OperacaoULA;
    logic        erro_instr;
    logic [31:0] instr_concluidas;

    int n_checks = 0;
    int n_pass   = 0;

    unidade_controle_multiciclo dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .opcode           (opcode),
        .zero             (zero),
        .mem_pronto       (mem_pronto),
        .mem_req          (mem_req),
        .OrigemEnd        (OrigemEnd),
        .EscreveMem       (EscreveMem),
        .EscreveIR        (EscreveIR),
        .EscrevePC        (EscrevePC),
        .EscreveReg       (EscreveReg),
        .OrigemA          (OrigemA),
        .OrigemB          (OrigemB),
        .OrigemResultado  (OrigemResultado),
        .OperacaoULA      (OperacaoULA),
        .erro_instr       (erro_instr),
        .instr_concluidas (instr_concluidas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, OrigemEnd, EscreveMem, EscreveIR, EscrevePC, EscreveReg,
    //  OrigemA, OrigemB, OrigemResultado, OperacaoULA}
    logic [13:0] saidas;
    assign saidas = {mem_req, OrigemEnd, EscreveMem, EscreveIR, EscrevePC, EscreveReg,
                     OrigemA, OrigemB, OrigemResultado, OperacaoULA};

    localparam logic [13:0] V_ZERO     = 14'b000000_00_00_00_00;
    localparam logic [13:0] V_BUSCA_P1 = 14'b100110_00_10_10_00;
    localparam logic [13:0] V_BUSCA_P0 = 14'b100000_00_10_10_00;
    localparam logic [13:0] V_DECOD    = 14'b000000_01_01_00_00;
    localparam logic [13:0] V_ENDMEM   = 14'b000000_10_01_00_00;
    localparam logic [13:0] V_LEMEM    = 14'b110000_00_00_00_00;
    localparam logic [13:0] V_ERM      = 14'b000001_00_00_01_00;
    localparam logic [13:0] V_ESCMEM   = 14'b111000_00_00_00_00;
    localparam logic [13:0] V_EXEC_R   = 14'b000000_10_00_00_10;
    localparam logic [13:0] V_EXEC_I   = 14'b000000_10_01_00_10;
    localparam logic [13:0] V_ULA_WB   = 14'b000001_00_00_00_00;
    localparam logic [13:0] V_BEQ_Z1   = 14'b000010_10_00_00_01;
    localparam logic [13:0] V_BEQ_Z0   = 14'b000000_10_00_00_01;
    localparam logic [13:0] V_JAL      = 14'b000010_01_10_00_00;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive inputs at the falling edge, then check the current state's outputs.
    task automatic ciclo(input string tag, input logic [6:0] opc, input logic pronto,
                         input logic z, input logic [13:0] esp);
        @(negedge clk);
        opcode     = opc;
        mem_pronto = pronto;
        zero       = z;
        #1;
        verifica(tag, {18'd0, saidas}, {18'd0, esp});
    endtask

    initial begin
        rst_n      = 1'b0;
        opcode     = 7'd0;
        zero       = 1'b0;
        mem_pronto = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        verifica("reset_saidas", {18'd0, saidas}, 32'd0);
        verifica("reset_contador", instr_concluidas, 32'd0);
        verifica("reset_erro", {31'd0, erro_instr}, 32'd0);

        // lw, zero-wait
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = OP_LW;
        #1;
        verifica("lw_inicio", {18'd0, saidas}, {18'd0, V_ZERO});
        ciclo("lw_busca", OP_LW, 1'b1, 1'b0, V_BUSCA_P1);
        ciclo("lw_decod", OP_LW, 1'b1, 1'b0, V_DECOD);
        ciclo("lw_endmem", OP_LW, 1'b1, 1'b0, V_ENDMEM);
        ciclo("lw_lemem", OP_LW, 1'b1, 1'b0, V_LEMEM);
        ciclo("lw_escreve_reg", OP_LW, 1'b1, 1'b0, V_ERM);
        verifica("lw_contador_antes", instr_concluidas, 32'd0);

        // sw with three wait cycles
        ciclo("sw_busca", OP_SW, 1'b1, 1'b0, V_BUSCA_P1);
        verifica("lw_contador_depois", instr_concluidas, 32'd1);
        ciclo("sw_decod", OP_SW, 1'b1, 1'b0, V_DECOD);
        ciclo("sw_endmem", OP_SW, 1'b1, 1'b0, V_ENDMEM);
        for (int i = 0; i < 3; i++) begin
            ciclo("sw_espera", OP_SW, 1'b0, 1'b0, V_ESCMEM);
            verifica("sw_contador_espera", instr_concluidas, 32'd1);
        end
        ciclo("sw_pronto", OP_SW, 1'b1, 1'b0, V_ESCMEM);

        // beq taken, then not taken
        ciclo("beq1_busca", OP_BEQ, 1'b1, 1'b1, V_BUSCA_P1);
        verifica("sw_contador", instr_concluidas, 32'd2);
        ciclo("beq1_decod", OP_BEQ, 1'b1, 1'b1, V_DECOD);
        ciclo("beq1_exec", OP_BEQ, 1'b1, 1'b1, V_BEQ_Z1);
        ciclo("beq0_busca", OP_BEQ, 1'b1, 1'b0, V_BUSCA_P1);
        ciclo("beq0_decod", OP_BEQ, 1'b1, 1'b0, V_DECOD);
        ciclo("beq0_exec", OP_BEQ, 1'b1, 1'b0, V_BEQ_Z0);

        // R-type across the counter wrap
        ciclo("r_busca", OP_R, 1'b1, 1'b0, V_BUSCA_P1);
        verifica("beq_contador", instr_concluidas, 32'd4);
        force dut.instr_concluidas_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_concluidas_q;
        ciclo("r_decod", OP_R, 1'b1, 1'b0, V_DECOD);
        ciclo("r_exec", OP_R, 1'b1, 1'b0, V_EXEC_R);
        ciclo("r_ula_wb", OP_R, 1'b1, 1'b0, V_ULA_WB);
        verifica("r_contador_cheio", instr_concluidas, 32'hFFFF_FFFF);

        // I-type then jal
        ciclo("i_busca", OP_I, 1'b1, 1'b0, V_BUSCA_P1);
        verifica("r_contador_wrap", instr_concluidas, 32'd0);
        ciclo("i_decod", OP_I, 1'b1, 1'b0, V_DECOD);
        ciclo("i_exec", OP_I, 1'b1, 1'b0, V_EXEC_I);
        ciclo("i_ula_wb", OP_I, 1'b1, 1'b0, V_ULA_WB);
        ciclo("jal_busca", OP_JAL, 1'b1, 1'b0, V_BUSCA_P1);
        verifica("i_contador", instr_concluidas, 32'd1);
        ciclo("jal_decod", OP_JAL, 1'b1, 1'b0, V_DECOD);
        ciclo("jal_exec", OP_JAL, 1'b1, 1'b0, V_JAL);
        ciclo("jal_ula_wb", OP_JAL, 1'b1, 1'b0, V_ULA_WB);

        // Fetch stall, then reset while lw waits on memory
        ciclo("lw2_busca_espera", OP_LW, 1'b0, 1'b0, V_BUSCA_P0);
        verifica("jal_contador", instr_concluidas, 32'd2);
        ciclo("lw2_busca", OP_LW, 1'b1, 1'b0, V_BUSCA_P1);
        ciclo("lw2_decod", OP_LW, 1'b1, 1'b0, V_DECOD);
        ciclo("lw2_endmem", OP_LW, 1'b1, 1'b0, V_ENDMEM);
        ciclo("lw2_lemem", OP_LW, 1'b0, 1'b0, V_LEMEM);
        #1;
        rst_n = 1'b0;
        #1;
        verifica("abort_saidas", {18'd0, saidas}, 32'd0);
        verifica("abort_contador", instr_concluidas, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        verifica("abort_inicio", {18'd0, saidas}, {18'd0, V_ZERO});

        // Illegal opcode traps in ERRO
        ciclo("ilegal_busca", 7'b0000000, 1'b1, 1'b0, V_BUSCA_P1);
        ciclo("ilegal_decod", 7'b0000000, 1'b1, 1'b0, V_DECOD);
        verifica("ilegal_erro_antes", {31'd0, erro_instr}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            ciclo("erro_saidas", 7'b0000000, 1'b1, 1'b0, V_ZERO);
            verifica("erro_flag", {31'd0, erro_instr}, 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        verifica("erro_reset", {31'd0, erro_instr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ciclo("reinicio_busca", OP_LW, 1'b1, 1'b0, V_BUSCA_P1);
        verifica("reinicio_erro", {31'd0, erro_instr}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
